// File: rtl/writeback_queue_stage.sv
// Write-back stage: selects the result source and queues up to DEPTH register writes while suspended.
// Latency is 1 cycle (bypass when empty). Queued writes drain in order. mem_ready falls when full; a dropped write sets sticky wb_overflow.
// Optional macro WB_ZERO_REG_EN: discards writes to r0 and never forwards r0.
module writeback_queue_stage #(
  parameter int DATA_W = 16,
  parameter int RID_W  = 4,
  parameter int DEPTH  = 4,
  parameter int SEMA_W = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     suspend_cpu,
  input  logic                     mem_valid,
  input  logic [DATA_W-1:0]        mem_alu_result,
  input  logic [RID_W-1:0]         mem_rd_id,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_to_reg,
  input  logic                     mem_sema_read_performed,
  input  logic [SEMA_W-1:0]        mem_sema_writeback,
  input  logic [DATA_W-1:0]        dmem_data_memory_read_data,
  output logic                     mem_ready,
  input  logic [RID_W-1:0]         fwd_rs_id,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [DATA_W-1:0]        wb_regfile_writeback,
  output logic [RID_W-1:0]         wb_rd_id,
  output logic                     wb_reg_write,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RID_W-1:0]  rd;
    logic [DATA_W-1:0] dat;
  } wb_entry_t;

  wb_entry_t         ent_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  logic [DATA_W-1:0] src_dat;
  wb_entry_t         new_ent;
  logic              zero_rd;
  logic              want;
  logic              accept;
  logic              pop;
  logic              push;
  logic              queue_empty;
  logic [PW-1:0]     fwd_idx;

  always_comb begin
    src_dat = mem_alu_result;
    if (mem_mem_to_reg) begin
      src_dat = mem_sema_read_performed ? DATA_W'(mem_sema_writeback)
                                        : dmem_data_memory_read_data;
    end
  end

  assign new_ent = '{rd: mem_rd_id, dat: src_dat};

`ifdef WB_ZERO_REG_EN
  assign zero_rd = (mem_rd_id == '0);
`else
  assign zero_rd = 1'b0;
`endif

  assign queue_empty = (count_q == '0);
  assign mem_ready   = (count_q < CW'(DEPTH));
  assign want        = mem_valid & mem_reg_write & ~zero_rd;
  assign accept      = want & mem_ready;
  assign pop         = ~suspend_cpu & ~queue_empty;
  // When running with an empty queue the entry bypasses straight to the output registers.
  assign push        = accept & (suspend_cpu | ~queue_empty);
  assign wb_count    = count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      wb_overflow          <= 1'b0;
      wb_reg_write         <= 1'b0;
      wb_rd_id             <= '0;
      wb_regfile_writeback <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= new_ent;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (want && !mem_ready) begin
        wb_overflow <= 1'b1;
      end

      if (suspend_cpu) begin
        wb_reg_write         <= 1'b0;
        wb_rd_id             <= '0;
        wb_regfile_writeback <= '0;
      end else if (pop) begin
        wb_reg_write         <= 1'b1;
        wb_rd_id             <= ent_q[head_q].rd;
        wb_regfile_writeback <= ent_q[head_q].dat;
      end else if (accept) begin
        wb_reg_write         <= 1'b1;
        wb_rd_id             <= new_ent.rd;
        wb_regfile_writeback <= new_ent.dat;
      end else begin
        wb_reg_write         <= 1'b0;
        wb_rd_id             <= '0;
        wb_regfile_writeback <= '0;
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; the output register is older than any queued entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    if (wb_reg_write && (wb_rd_id == fwd_rs_id)) begin
      fwd_hit  = 1'b1;
      fwd_data = wb_regfile_writeback;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_q[fwd_idx].rd == fwd_rs_id)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_q[fwd_idx].dat;
      end
    end
`ifdef WB_ZERO_REG_EN
    if (fwd_rs_id == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
`endif
  end

endmodule

// File: tb/tb_writeback_queue_stage.sv
// Bench for writeback_queue_stage: directed scenarios with literal expectations plus random traffic against a queue model.
module tb_writeback_queue_stage;

  localparam int DATA_W = 16;
  localparam int RID_W  = 4;
  localparam int DEPTH  = 4;
  localparam int SEMA_W = 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              suspend_cpu;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [RID_W-1:0]  mem_rd_id;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic              mem_sema_read_performed;
  logic [SEMA_W-1:0] mem_sema_writeback;
  logic [DATA_W-1:0] dmem_data_memory_read_data;
  logic              mem_ready;
  logic [RID_W-1:0]  fwd_rs_id;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] wb_regfile_writeback;
  logic [RID_W-1:0]  wb_rd_id;
  logic              wb_reg_write;
  logic [CW-1:0]     wb_count;
  logic              wb_overflow;

  writeback_queue_stage #(.DATA_W(DATA_W), .RID_W(RID_W), .DEPTH(DEPTH), .SEMA_W(SEMA_W)) dut (
    .clk(clk), .rstn(rstn), .suspend_cpu(suspend_cpu), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_rd_id(mem_rd_id), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_sema_read_performed(mem_sema_read_performed),
    .mem_sema_writeback(mem_sema_writeback), .dmem_data_memory_read_data(dmem_data_memory_read_data),
    .mem_ready(mem_ready), .fwd_rs_id(fwd_rs_id), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .wb_regfile_writeback(wb_regfile_writeback), .wb_rd_id(wb_rd_id), .wb_reg_write(wb_reg_write),
    .wb_count(wb_count), .wb_overflow(wb_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the word currently on the write port.
  typedef struct {
    logic [RID_W-1:0]  rd;
    logic [DATA_W-1:0] dat;
  } ent_t;

  ent_t              mq[$];
  bit                m_ovf;
  bit                m_vld;
  logic [RID_W-1:0]  m_rd;
  logic [DATA_W-1:0] m_dat;

  function automatic logic [DATA_W-1:0] src_value();
    if (!mem_mem_to_reg) return mem_alu_result;
    if (mem_sema_read_performed) return DATA_W'(mem_sema_writeback);
    return dmem_data_memory_read_data;
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    bit   want;
    bit   ready;
    ent_t e;
    ent_t h;
    if (!rstn) begin
      mq.delete();
      m_ovf = 0; m_vld = 0; m_rd = '0; m_dat = '0;
    end else begin
      want = mem_valid && mem_reg_write;
`ifdef WB_ZERO_REG_EN
      if (mem_rd_id == 0) want = 0;
`endif
      ready = (mq.size() < DEPTH);
      if (want && !ready) m_ovf = 1;
      e.rd  = mem_rd_id;
      e.dat = src_value();
      if (suspend_cpu) begin
        m_vld = 0; m_rd = '0; m_dat = '0;
        if (want && ready) mq.push_back(e);
      end else if (mq.size() == 0) begin
        if (want && ready) begin
          m_vld = 1; m_rd = e.rd; m_dat = e.dat;
        end else begin
          m_vld = 0; m_rd = '0; m_dat = '0;
        end
      end else begin
        h = mq.pop_front();
        m_vld = 1; m_rd = h.rd; m_dat = h.dat;
        if (want && ready) mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit                h;
    logic [DATA_W-1:0] d;
    h = 0; d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!h && mq[i].rd == fwd_rs_id) begin
        h = 1; d = mq[i].dat;
      end
    end
    if (!h && m_vld && m_rd == fwd_rs_id) begin
      h = 1; d = m_dat;
    end
`ifdef WB_ZERO_REG_EN
    if (fwd_rs_id == 0) begin h = 0; d = '0; end
`endif
    check("cyc wb_reg_write", wb_reg_write, m_vld);
    check("cyc wb_rd_id", wb_rd_id, m_rd);
    check("cyc wb_data", wb_regfile_writeback, m_dat);
    check("cyc wb_count", wb_count, mq.size());
    check("cyc mem_ready", mem_ready, mq.size() < DEPTH);
    check("cyc wb_overflow", wb_overflow, m_ovf);
    check("cyc fwd_hit", fwd_hit, h);
    check("cyc fwd_data", fwd_data, d);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [RID_W-1:0] rd, input logic [DATA_W-1:0] alu);
    mem_valid = v; mem_reg_write = 1'b1; mem_rd_id = rd; mem_alu_result = alu;
    mem_mem_to_reg = 1'b0; mem_sema_read_performed = 1'b0;
  endtask

  initial begin : stim
    int pulses;
    logic [RID_W-1:0] order [$];
    rstn = 1'b0; suspend_cpu = 1'b0; mem_valid = 1'b0; mem_alu_result = '0; mem_rd_id = '0;
    mem_reg_write = 1'b0; mem_mem_to_reg = 1'b0; mem_sema_read_performed = 1'b0;
    mem_sema_writeback = '0; dmem_data_memory_read_data = '0; fwd_rs_id = '0;
    repeat (2) cyc();
    check("reset wb_reg_write", wb_reg_write, 0);
    check("reset wb_count", wb_count, 0);
    check("reset mem_ready", mem_ready, 1);
    check("reset wb_overflow", wb_overflow, 0);
    rstn = 1'b1;
    cyc();

    drive(1, 4'd3, 16'h1234);
    cyc();
    check("bypass vld", wb_reg_write, 1);
    check("bypass rd", wb_rd_id, 3);
    check("bypass data", wb_regfile_writeback, 16'h1234);
    mem_valid = 0;
    cyc();
    check("bypass single pulse", wb_reg_write, 0);

    drive(1, 4'd4, 16'h5555);
    mem_mem_to_reg = 1; mem_sema_read_performed = 1; mem_sema_writeback = 1'b1;
    dmem_data_memory_read_data = 16'hBEEF;
    cyc();
    check("sema select", wb_regfile_writeback, 16'h0001);
    mem_sema_read_performed = 0;
    cyc();
    check("dmem select", wb_regfile_writeback, 16'hBEEF);
    mem_valid = 0;
    cyc();

    suspend_cpu = 1;
    drive(1, 4'd1, 16'h11); cyc();
    check("susp no write 1", wb_reg_write, 0);
    drive(1, 4'd2, 16'h22); cyc();
    drive(1, 4'd3, 16'h33); cyc();
    check("susp no write 3", wb_reg_write, 0);
    check("susp count", wb_count, 3);
    mem_valid = 0; fwd_rs_id = 2; #1;
    check("fwd queued hit", fwd_hit, 1);
    check("fwd queued data", fwd_data, 16'h22);
    suspend_cpu = 0;
    order.delete();
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (wb_reg_write) order.push_back(wb_rd_id);
    end
    check("drain pulses", order.size(), 3);
    if (order.size() == 3) begin
      check("drain order 0", order[0], 1);
      check("drain order 1", order[1], 2);
      check("drain order 2", order[2], 3);
    end
    check("drain count", wb_count, 0);

    suspend_cpu = 1;
    drive(1, 4'd5, 16'hAAAA); cyc();
    drive(1, 4'd5, 16'hBBBB); cyc();
    mem_valid = 0; fwd_rs_id = 5; #1;
    check("fwd youngest hit", fwd_hit, 1);
    check("fwd youngest data", fwd_data, 16'hBBBB);
    fwd_rs_id = 6; #1;
    check("fwd miss hit", fwd_hit, 0);
    check("fwd miss data", fwd_data, 0);
    suspend_cpu = 0;
    repeat (3) cyc();

    suspend_cpu = 1;
    for (int k = 0; k < 5; k++) begin
      drive(1, RID_W'(k + 1), DATA_W'(16'h100 + k));
      cyc();
      if (k == 3) check("full ready", mem_ready, 0);
    end
    check("full count", wb_count, 4);
    check("overflow set", wb_overflow, 1);
    mem_valid = 0; suspend_cpu = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (wb_reg_write) pulses++;
    end
    check("full drain pulses", pulses, 4);
    check("overflow sticky", wb_overflow, 1);

    suspend_cpu = 1;
    drive(1, 4'd7, 16'h77); cyc();
    drive(1, 4'd8, 16'h88); cyc();
    drive(1, 4'd9, 16'h99); cyc();
    check("pre-reset count", wb_count, 3);
    mem_valid = 0; suspend_cpu = 0;
    cyc();
    check("mid-drain pulse", wb_reg_write, 1);
    #1 rstn = 0;
    #1;
    check("async rst wb_reg_write", wb_reg_write, 0);
    check("async rst wb_rd_id", wb_rd_id, 0);
    check("async rst data", wb_regfile_writeback, 0);
    check("async rst count", wb_count, 0);
    check("async rst overflow", wb_overflow, 0);
    #1 rstn = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (wb_reg_write) pulses++;
    end
    check("no pulses after reset", pulses, 0);

`ifdef WB_ZERO_REG_EN
    drive(1, 4'd0, 16'hDEAD); cyc();
    check("zero reg no pulse", wb_reg_write, 0);
    check("zero reg no count", wb_count, 0);
    mem_valid = 0; fwd_rs_id = 0; #1;
    check("zero reg no fwd", fwd_hit, 0);
    cyc();
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) suspend_cpu = ~suspend_cpu;
      mem_valid                  = ($urandom_range(0, 2) != 0);
      mem_reg_write              = ($urandom_range(0, 4) != 0);
      mem_rd_id                  = RID_W'($urandom_range(0, 7));
      mem_alu_result             = DATA_W'($urandom);
      dmem_data_memory_read_data = DATA_W'($urandom);
      mem_mem_to_reg             = $urandom_range(0, 1) == 1;
      mem_sema_read_performed    = $urandom_range(0, 1) == 1;
      mem_sema_writeback         = SEMA_W'($urandom);
      fwd_rs_id                  = RID_W'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        rstn = 0;
        #1 rstn = 1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_queue_stage.md
Name: writeback_queue_stage

Overview:
Registered, parametrised write-back stage between the MEM stage and the register file.
- Selects the write-back source: ALU result, data-memory read data, or zero-extended semaphore result.
- Buffers up to DEPTH pending register writes while suspend_cpu is high, so they are no longer discarded.
- Drains buffered writes in order, one per cycle, once suspend_cpu is low.
- Provides a forwarding lookup over all pending and in-flight writes.

Parameters:
DATA_W, 16, register/data width
RID_W, 4, register identifier width
DEPTH, 4, pending-write FIFO entries; power of 2, >=2
SEMA_W, 1, semaphore result width; zero-extended to DATA_W

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
suspend_cpu  in  1  high = hold register-file writes
mem_valid  in  1  MEM stage presents a retiring instruction this cycle
mem_alu_result  in  DATA_W  ALU result
mem_rd_id  in  RID_W  destination register
mem_reg_write  in  1  instruction writes a register
mem_mem_to_reg  in  1  source = memory path
mem_sema_read_performed  in  1  memory path = semaphore result
mem_sema_writeback  in  SEMA_W  semaphore result
dmem_data_memory_read_data  in  DATA_W  data memory read data
mem_ready  out  1  space available (count < DEPTH)
fwd_rs_id  in  RID_W  forwarding lookup register id
fwd_hit  out  1  pending/in-flight write to fwd_rs_id exists
fwd_data  out  DATA_W  youngest matching value
wb_regfile_writeback  out  DATA_W  register-file write data
wb_rd_id  out  RID_W  register-file write address
wb_reg_write  out  1  register-file write enable (one cycle per entry)
wb_count  out  clog2(DEPTH)+1  FIFO occupancy
wb_overflow  out  1  sticky: write dropped because full

Behaviour:
- Source select (combinational):
  - mem_mem_to_reg=0 -> mem_alu_result.
  - mem_mem_to_reg=1 and sema=1 -> {zeros, mem_sema_writeback}.
  - mem_mem_to_reg=1 and sema=0 -> dmem read data.
- Accept = mem_valid & mem_reg_write & mem_ready.
  - Entries with mem_reg_write=0 are never stored.
- mem_ready = (count < DEPTH), derived from the registered count only.
  - A pop in the same cycle does not raise mem_ready.
- Reset (rstn low, any time, asynchronous): wb_* = 0, count = 0, pointers = 0, wb_overflow = 0, and FIFO contents are invalidated.
  - A reset in the middle of a drain discards all pending entries.
- Per posedge, with rstn high:
  - suspend_cpu=1:
    - Output registers are cleared: wb_reg_write=0, wb_rd_id=0, data=0.
    - An accepted entry is pushed at the tail.
  - suspend_cpu=0, count=0, accept:
    - Bypass: the entry is loaded directly into the output registers with wb_reg_write=1.
    - Latency is 1 cycle.
  - suspend_cpu=0, count>0:
    - The head is popped into the output registers with wb_reg_write=1.
    - An accepted entry is pushed at the tail in the same cycle; count is unchanged.
  - suspend_cpu=0, count=0, no accept: output registers are cleared.
- Ordering: strict FIFO. Each accepted entry produces exactly one wb_reg_write pulse.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never exceeds DEPTH.
- Full: mem_valid & mem_reg_write & !mem_ready -> the entry is dropped and wb_overflow is set.
  - wb_overflow is cleared only by reset.
- Forwarding (combinational), priority youngest first:
  1. Valid FIFO entries, from tail-1 back to the head.
  2. The output register, when wb_reg_write=1.
  - fwd_hit=1 and fwd_data = the first match; otherwise fwd_hit=0 and fwd_data=0.
  - Incoming MEM data is not included in the lookup.

Optional Feature:
WB_ZERO_REG_EN
- Defined:
  - Writes with mem_rd_id=0 are discarded at acceptance: not stored, not counted, no overflow, no wb pulse.
  - fwd_rs_id=0 always returns fwd_hit=0, fwd_data=0.
- Undefined: register 0 is treated like any other register.

Test Plan:
- Write, no suspend: suspend=0, alu=0x1234, rd=3, reg_write=1, valid=1 -> next cycle wb_reg_write=1, rd=3, data=0x1234; the cycle after that, wb_reg_write=0.
- Source select: mem_to_reg=1, sema=1, sema_wb=1, dmem=0xBEEF -> data=0x0001. With sema=0 -> data=0xBEEF.
- Suspend and drain: suspend=1, push rd=1/0x11, rd=2/0x22, rd=3/0x33 -> wb_reg_write=0 throughout, wb_count=3. Release -> three consecutive pulses in the order 1, 2, 3; count returns to 0.
- Full and overflow (DEPTH=4): while suspended, push 5 entries -> mem_ready=0 after the 4th, the 5th is dropped, wb_overflow=1. Release -> exactly 4 pulses; overflow stays 1 until rstn pulse.
- Forwarding: buffer holds rd=5/0xAAAA (older) and rd=5/0xBBBB (newer), fwd_rs_id=5 -> fwd_hit=1, fwd_data=0xBBBB. fwd_rs_id=6 -> fwd_hit=0, fwd_data=0.
- Reset mid-drain: count=3, assert rstn=0 asynchronously -> all outputs 0 immediately, no further pulses after release. With WB_ZERO_REG_EN defined, rd=0 writes produce no pulse and no count change.
